// File: rtl/req_pkg.sv
// Shared constants, FSM state type and priority helper for the request
// capture stage.
package req_pkg;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned CODE_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_e;

  // Highest set bit wins; an all-zero mask yields 0.
  function automatic logic [CODE_W-1:0] prio_index(input logic [N_REQ-1:0] mask);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (mask[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_sync_edge.sv
// One request line: SYNC_STAGES-deep synchroniser followed by a prev flop;
// rise flags a synchronised 0->1 transition.
module req_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/req_capture_encoder.sv
// Captures synchronised request edges into sticky pending bits and presents
// the highest-priority one as a registered code with a valid/ack handshake.
module req_capture_encoder
  import req_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_in,
  input  logic              ack,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  pending,
  output logic              overflow,
  input  logic              clr_ovf
);

  logic [N_REQ-1:0]  rise;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  clear_vec;
  logic              overflow_q, overflow_d;
  logic              ovf_set;
  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;

  for (genvar g = 0; g < N_REQ; g++) begin : g_line
    req_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (req_in[g]),
      .rise (rise[g])
    );
  end

  // A coincident rise re-sets a bit being cleared, so set wins without
  // counting as an overflow.
  always_comb begin
    clear_vec  = (ack && valid_q) ? (N_REQ'(1) << code_q) : '0;
    pending_d  = (pending_q & ~clear_vec) | rise;
    ovf_set    = |(rise & pending_q & ~clear_vec);
    overflow_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          code_d  = prio_index(pending_q);
        end
      end
      PRESENT: begin
        if (ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      code_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid    = valid_q;
  assign code     = code_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_req_capture_encoder.sv
// Self-checking bench for req_capture_encoder: vector table of request
// patterns with expected grant order, plus hand-written corner sequences.
module tb_req_capture_encoder;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic       ack;
  logic       valid;
  logic [1:0] code;
  logic [3:0] pending;
  logic       overflow;
  logic       clr_ovf;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [1:0]  sb[$];

  typedef struct packed {
    logic [3:0] req;
    logic [2:0] n;
    logic [7:0] codes;  // grant k expected in codes[2k+:2]
  } vec_t;

  vec_t vecs[6];

  req_capture_encoder #(
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .ack      (ack),
    .valid    (valid),
    .code     (code),
    .pending  (pending),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm);
    int unsigned n;
    n = 0;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
    if (!valid) begin
      checks++;
      errors++;
      $display("FAIL %s: valid timeout got 0 expected 1", nm);
    end
  endtask

  task automatic pop_check(input string nm);
    logic [1:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected grant code %0h, scoreboard empty", nm, code);
    end else begin
      e = sb.pop_front();
      chk(nm, 32'(code), 32'(e));
    end
  endtask

  // Waits for a grant, checks it against the scoreboard, acks one cycle.
  task automatic serve(input string nm);
    wait_valid(nm);
    pop_check(nm);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({nm, "_vfall"}, 32'(valid), 32'd0);
  endtask

  task automatic settle();
    req_in = '0;
    repeat (5) tick();
  endtask

  initial begin
    int unsigned grants;
    int          last_cyc;
    int unsigned vcount;

    rst     = 1'b1;
    req_in  = '0;
    ack     = 1'b0;
    clr_ovf = 1'b0;
    vecs[0] = '{4'b0100, 3'd1, 8'h02};
    vecs[1] = '{4'b1001, 3'd2, 8'h03};
    vecs[2] = '{4'b1111, 3'd4, 8'h1B};
    vecs[3] = '{4'b0110, 3'd2, 8'h06};
    vecs[4] = '{4'b0001, 3'd1, 8'h00};
    vecs[5] = '{4'b1010, 3'd2, 8'h07};

    repeat (3) tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Table: simultaneous request patterns, grants in priority order.
    for (int v = 0; v < 6; v++) begin
      req_in = vecs[v].req;
      for (int k = 0; k < int'(vecs[v].n); k++) sb.push_back(vecs[v].codes[2*k +: 2]);
      repeat (3) tick();
      chk("vec_pending_set", 32'(pending), 32'(vecs[v].req));
      chk("vec_valid_early", 32'(valid), 32'd0);
      tick();
      chk("vec_valid_latency", 32'(valid), 32'd1);
      for (int k = 0; k < int'(vecs[v].n); k++) serve("vec_grant");
      chk("vec_pending_clear", 32'(pending), 32'd0);
      settle();
      chk("vec_idle_valid", 32'(valid), 32'd0);
    end

    // No pre-emption by a later higher-priority request.
    req_in = 4'b0010;
    sb.push_back(2'b01);
    wait_valid("npe_first");
    chk("npe_code", 32'(code), 32'd1);
    req_in = 4'b1010;
    sb.push_back(2'b11);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("npe_hold_valid", 32'(valid), 32'd1);
      chk("npe_hold_code", 32'(code), 32'd1);
    end
    chk("npe_pending", 32'(pending), 32'b1010);
    serve("npe_grant1");
    serve("npe_grant2");
    settle();

    // Overflow: re-pulse line 1 while it is pending and unserved.
    req_in = 4'b0010;
    sb.push_back(2'b01);
    repeat (2) tick();
    req_in = '0;
    wait_valid("ovf_first");
    pop_check("ovf_first_code");
    repeat (4) tick();
    req_in = 4'b0010;
    repeat (2) tick();
    req_in = '0;
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_pending", 32'(pending), 32'b0010);
    repeat (3) tick();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_code_held", 32'(code), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ovf_ack_pending", 32'(pending), 32'd0);
    settle();
    chk("ovf_no_regrant", 32'(valid), 32'd0);

    // Set wins: re-pulse of line 1 lands on the edge that acks line 1.
    req_in = 4'b0010;
    sb.push_back(2'b01);
    repeat (2) tick();
    req_in = '0;
    wait_valid("sw_first");
    pop_check("sw_first_code");
    repeat (4) tick();
    req_in = 4'b0010;
    sb.push_back(2'b01);
    repeat (2) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req_in = '0;
    chk("sw_pending_kept", 32'(pending), 32'b0010);
    chk("sw_no_overflow", 32'(overflow), 32'd0);
    chk("sw_valid_fall", 32'(valid), 32'd0);
    serve("sw_regrant");
    chk("sw_pending_done", 32'(pending), 32'd0);
    settle();

    // Reset mid-operation, req_in[2] held through release.
    req_in = 4'b1010;
    sb.push_back(2'b11);
    sb.push_back(2'b01);
    wait_valid("rmo_first");
    chk("rmo_code", 32'(code), 32'd3);
    chk("rmo_pending", 32'(pending), 32'b1010);
    @(negedge clk);
    rst    = 1'b1;
    req_in = 4'b0100;
    #1;
    chk("rmo_valid", 32'(valid), 32'd0);
    chk("rmo_code0", 32'(code), 32'd0);
    chk("rmo_pending0", 32'(pending), 32'd0);
    chk("rmo_overflow0", 32'(overflow), 32'd0);
    sb.delete();
    sb.push_back(2'b10);
    repeat (3) tick();
    rst = 1'b0;
    serve("rmo_after");
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid) vcount++;
    end
    chk("rmo_single_grant", vcount, 32'd0);
    chk("rmo_pending_end", 32'(pending), 32'd0);
    settle();

    // Ack while valid=0 is ignored.
    req_in = 4'b0001;
    sb.push_back(2'b00);
    repeat (3) tick();
    chk("ah_pending", 32'(pending), 32'b0001);
    chk("ah_valid0", 32'(valid), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ah_pending_kept", 32'(pending), 32'b0001);
    chk("ah_valid1", 32'(valid), 32'd1);
    serve("ah_grant");
    settle();

    // Ack held high: one grant every 2 cycles.
    ack    = 1'b1;
    req_in = 4'b1111;
    sb.push_back(2'b11);
    sb.push_back(2'b10);
    sb.push_back(2'b01);
    sb.push_back(2'b00);
    grants   = 0;
    last_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (valid) begin
        pop_check("cont_code");
        if (last_cyc >= 0) chk("cont_spacing", 32'(c - last_cyc), 32'd2);
        last_cyc = c;
        grants++;
      end
    end
    chk("cont_grants", grants, 32'd4);
    ack = 1'b0;
    settle();
    chk("cont_pending", 32'(pending), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_capture_encoder.md
# req_capture_encoder

Request capture stage that sits directly upstream of the team's 4-line priority encoder path. It synchronises four asynchronous request lines and converts each rising edge into a sticky pending bit. It then presents the highest-priority pending request as a 2-bit code with a valid/ack handshake, and clears the served bit on acknowledge. The consumer downstream sees a stable, registered code instead of raw, glitchy request levels.

## Interface
- N_REQ, 4, number of request lines; fixed at 4 in this revision because the code is 2 bits.
- SYNC_STAGES, 2, synchroniser depth per request line; legal range 1..3.
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  N_REQ  asynchronous request levels; a 0->1 transition is one event.
- ack  input  1  consumer accepts the presented code; only meaningful while valid=1.
- valid  output  1  code holds a pending request.
- code  output  2  index of the served request; bit 3 = highest priority (2'b11), bit 0 = lowest (2'b00).
- pending  output  N_REQ  current pending mask.
- overflow  output  1  sticky flag: an event arrived on a line whose pending bit was already set.
- clr_ovf  input  1  synchronous clear of overflow.

## Operation
- Per line: SYNC_STAGES flops, then a prev flop. rise = sync_out & ~prev.
- pending[i] is set on rise[i]. It is cleared when ack && valid && code==i.
- If a set and a clear hit the same bit in the same cycle, the set wins: the bit stays 1 and overflow is not raised.
- overflow is set when rise[i] && pending[i] and bit i is not being cleared in that cycle.
- If clr_ovf and a new overflow condition occur in the same cycle, set wins.
- FSM states are IDLE and PRESENT.
  - IDLE: valid=0. If pending != 0, latch code = index of the highest set bit and go to PRESENT.
  - PRESENT: valid=1 and code is held stable. A newly pending higher-priority line does not pre-empt the current code. On ack, clear the served bit and return to IDLE.
- ack while valid=0 is ignored.
- Reset values: valid=0, code=2'b00, pending=0, overflow=0, state=IDLE, all sync and prev flops=0.
- Reset mid-operation drops the presented request and all pending events without any handshake.
- A req_in held high through reset release produces exactly one event after reset.

## Timing
- Let req_in[i] rise before clk edge t0. pending[i] is set at edge t0+SYNC_STAGES. valid rises at edge t0+SYNC_STAGES+1 when the FSM is in IDLE.
- The ack handshake completes at the clock edge where ack=1 and valid=1.
  - valid falls on that edge.
  - The next code is presented one cycle later, at the earliest.
  - Maximum throughput is therefore one grant every 2 cycles.
- code changes only on the IDLE->PRESENT transition. It is never modified while valid=1.
- A pulse on req_in shorter than one clk period may be missed. Sources must hold req_in for at least 2 clk cycles.
- pending and overflow are registered outputs. No combinational path runs from any input to any output.

## Structure
- Package req_pkg holds:
  - N_REQ.
  - CODE_W = $clog2(N_REQ).
  - The FSM state enum: IDLE, PRESENT.
  - A function prio_index(mask) returning the highest set bit index.
- Sub-module req_sync_edge holds one line's SYNC_STAGES-deep synchroniser, prev flop and rise output. It is instantiated N_REQ times with a generate loop.
- The top level holds the pending register, the overflow logic, the FSM and the output registers.

## Test plan
- Single event: raise req_in=4'b0100 with SYNC_STAGES=2 -> valid=1 and code=2'b10 at edge t0+3; ack for one cycle -> valid=0 and pending=4'b0000.
- Priority order: raise req_in=4'b1001 in one cycle -> first grant code=2'b11; after ack -> code=2'b00; after second ack -> pending=0, valid stays 0.
- No pre-emption: code=2'b01 is presented, then req_in[3] rises -> code stays 2'b01 until ack, and the next grant is code=2'b11.
- Overflow and set-wins:
  - Re-pulse req_in[1] while pending[1]=1 and unserved -> overflow=1, held until clr_ovf.
  - A re-pulse that coincides with the ack of line 1 -> pending[1] stays 1 and overflow stays 0.
- Reset: assert rst while valid=1 with pending=4'b1010 -> all outputs go to 0 immediately. Keep req_in[2] high through reset release -> exactly one grant with code=2'b10 follows.
- Ack hygiene: pulse ack while valid=0 -> pending is unchanged. Hold ack high continuously -> grants occur every 2 cycles and code is stable in every cycle where valid=1.
